// File: rtl/fir_sched_pkg.sv
// Shared defaults, widths and FSM state type for the FIR sample scheduler.
package fir_sched_pkg;
  localparam int DIV_DEFAULT     = 20;
  localparam int DEPTH_DEFAULT   = 4;
  localparam int OUT_LAT_DEFAULT = 2;
  localparam int SAMPLE_W        = 3;
  localparam int RESULT_W        = 16;
  localparam int CNT_W           = 8;   // wide enough for DIV up to 255

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } schedState_e;
endpackage

// File: rtl/fir_in_fifo.sv
// Small input sample FIFO with a registered read port and a registered ready flag.
module fir_in_fifo
  import fir_sched_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                iClk_12MHz,
  input  logic                iRst,
  input  logic                push,
  input  logic [SAMPLE_W-1:0] pushData,
  input  logic                pop,
  output logic [SAMPLE_W-1:0] popData,
  output logic                empty,
  output logic                pushReady
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [SAMPLE_W-1:0] mem [DEPTH];
  logic [AW-1:0]       wrPtr;
  logic [AW-1:0]       rdPtr;
  logic [CW-1:0]       count;
  logic [CW-1:0]       countNext;
  logic                doPush;
  logic                doPop;
  logic                fullNext;

  assign empty    = (count == '0);
  assign doPush   = push && pushReady;
  assign doPop    = pop && !empty;
  assign fullNext = (countNext == CW'(DEPTH));

  always_comb begin
    countNext = count;
    case ({doPush, doPop})
      2'b10:   countNext = count + CW'(1);
      2'b01:   countNext = count - CW'(1);
      default: countNext = count;
    endcase
  end

  always_ff @(posedge iClk_12MHz) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  // A pop on an empty FIFO still loads the read register, with zero.
  always_ff @(posedge iClk_12MHz) begin
    if (iRst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      pushReady <= 1'b0;
      popData   <= '0;
    end else begin
      count     <= countNext;
      pushReady <= !fullNext;
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      if (pop)    popData <= empty ? '0 : mem[rdPtr];
    end
  end
endmodule

// File: rtl/fir_sample_sched.sv
// Paces samples from the input FIFO into the FIR at DIV-cycle intervals and captures its result.
module fir_sample_sched
  import fir_sched_pkg::*;
#(
  parameter int DIV     = DIV_DEFAULT,
  parameter int DEPTH   = DEPTH_DEFAULT,
  parameter int OUT_LAT = OUT_LAT_DEFAULT
) (
  input  logic                iClk_12MHz,
  input  logic                iRst,
  input  logic                iEn,
  input  logic                iInValid,
  input  logic [SAMPLE_W-1:0] iInData,
  output logic                oInReady,
  output logic                oEnSample_600kHz,
  output logic [SAMPLE_W-1:0] oFirIn,
  input  logic [RESULT_W-1:0] iFirOut,
  output logic                oOutValid,
  output logic [RESULT_W-1:0] oOutData,
  input  logic                iClrErr,
  output logic                oUnderrun
);
  localparam logic [CNT_W-1:0] LAST_PHASE = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] PRE_PHASE  = CNT_W'(DIV - 2);
  localparam logic [CNT_W-1:0] CAP_DELAY  = CNT_W'(OUT_LAT);

  schedState_e      state;
  logic [CNT_W-1:0] phaseCnt;
  logic [CNT_W-1:0] capCnt;
  logic             popNow;
  logic             fifoEmpty;
  logic             underrunStrobe;

  // Outputs are registered, so the strobe and its pop are decided one cycle early.
  assign popNow = (state == RUN) && iEn && (phaseCnt == PRE_PHASE);

  fir_in_fifo #(.DEPTH(DEPTH)) uInFifo (
    .iClk_12MHz (iClk_12MHz),
    .iRst       (iRst),
    .push       (iInValid),
    .pushData   (iInData),
    .pop        (popNow),
    .popData    (oFirIn),
    .empty      (fifoEmpty),
    .pushReady  (oInReady)
  );

  always_ff @(posedge iClk_12MHz) begin
    if (iRst) begin
      state            <= IDLE;
      phaseCnt         <= '0;
      capCnt           <= '0;
      oEnSample_600kHz <= 1'b0;
      oOutValid        <= 1'b0;
      oOutData         <= '0;
      oUnderrun        <= 1'b0;
      underrunStrobe   <= 1'b0;
    end else begin
      oEnSample_600kHz <= popNow;
      underrunStrobe   <= popNow && fifoEmpty;

      // A clear arriving with the underrun strobe itself is ignored.
      if (popNow && fifoEmpty)
        oUnderrun <= 1'b1;
      else if (iClrErr && !underrunStrobe)
        oUnderrun <= 1'b0;

      // capCnt counts down to the capture edge; it is idle at zero.
      oOutValid <= (capCnt == CNT_W'(1));
      if (capCnt == CNT_W'(1)) oOutData <= iFirOut;
      if (popNow)
        capCnt <= CAP_DELAY;
      else if (capCnt != '0)
        capCnt <= capCnt - CNT_W'(1);

      case (state)
        IDLE: begin
          phaseCnt <= '0;
          if (iEn) state <= RUN;
        end
        RUN: begin
          if (!iEn) begin
            phaseCnt <= '0;
            state    <= (capCnt != '0) ? FLUSH : IDLE;
          end else begin
            phaseCnt <= (phaseCnt == LAST_PHASE) ? '0 : phaseCnt + CNT_W'(1);
          end
        end
        FLUSH: begin
          phaseCnt <= '0;
          if (capCnt <= CNT_W'(1)) state <= IDLE;
        end
        default: begin
          phaseCnt <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/fir_sample_sched.md
FIR_SAMPLE_SCHED -- requirements
Module: fir_sample_sched

Interface
REQ-001 Parameter DIV, default 20, is clock cycles per sample period (12 MHz / 20 = 600 kHz); legal range 4..255.
REQ-002 Parameter DEPTH, default 4, is input FIFO depth; power of two, 2..16.
REQ-003 Parameter OUT_LAT, default 2, is cycles from sample strobe to FIR output capture; legal range 1..DIV-1.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 iClk_12MHz  in  1  sole clock.
REQ-006 iRst  in  1  synchronous active-high reset.
REQ-007 iEn  in  1  run enable; level.
REQ-008 iInValid  in  1  upstream sample valid.
REQ-009 iInData  in  3  upstream sample, two's complement.
REQ-010 oInReady  out  1  FIFO can accept; registered, equals not-full.
REQ-011 oEnSample_600kHz  out  1  one-cycle sample strobe to FIR.
REQ-012 oFirIn  out  3  sample to FIR; valid in the strobe cycle.
REQ-013 iFirOut  in  16  FIR filter result.
REQ-014 oOutValid  out  1  one-cycle result-valid pulse.
REQ-015 oOutData  out  16  captured FIR result; held between pulses.
REQ-016 iClrErr  in  1  clears oUnderrun.
REQ-017 oUnderrun  out  1  sticky: strobe issued with FIFO empty.

Function
REQ-018 FSM states: IDLE, RUN, FLUSH; all outputs registered.
REQ-019 IDLE: phase counter held 0, no strobes; iEn=1 -> RUN next cycle.
REQ-020 RUN: phase counter counts 0..DIV-1 and wraps to 0; oEnSample_600kHz=1 exactly in cycles where counter==DIV-1 (first strobe in the DIV-th cycle after RUN entry, then every DIV cycles).
REQ-021 At each strobe, the FIFO head is popped and driven on oFirIn in the same cycle; oFirIn holds that value until the next strobe.
REQ-022 FIFO empty at strobe: oFirIn=3'b000, strobe still issued, oUnderrun set.
REQ-023 A push is accepted only when iInValid=1 and oInReady=1; data pushed in a strobe cycle is not visible to that strobe's pop.
REQ-024 Push and pop in the same cycle leave occupancy unchanged; pointers wrap modulo DEPTH.
REQ-025 OUT_LAT cycles after each strobe, oOutData<=iFirOut and oOutValid=1 for one cycle.
REQ-026 RUN with iEn=0: go to FLUSH if a capture is pending, else IDLE; no new strobe in either state.
REQ-027 FLUSH: complete the pending capture (REQ-025), then IDLE; iEn=1 during FLUSH is ignored until IDLE.
REQ-028 FIFO contents SHALL be retained across IDLE/FLUSH.
REQ-029 iClrErr=1 clears oUnderrun next cycle; a simultaneous underrun event SHALL take priority (oUnderrun remains 1).

Reset
REQ-030 iRst=1 -> state IDLE, counters 0, FIFO empty, pending capture discarded, even mid-operation.
REQ-031 Reset values: oEnSample_600kHz=0, oFirIn=0, oOutValid=0, oOutData=0, oUnderrun=0, oInReady=0.
REQ-032 oInReady=1 in the first cycle after iRst deasserts.

Structure
REQ-033 Package fir_sched_pkg SHALL hold DIV/DEPTH/OUT_LAT defaults, the FSM state enum, and sample (3-bit) and result (16-bit) width constants.
REQ-034 FIFO SHALL be sub-module fir_in_fifo (push/pop, full/empty); FSM, phase counter and capture timer stay in fir_sample_sched.

Verification
REQ-035 Reset, then iEn=1 with FIFO preloaded 3'b111,3'b001 -> strobes at RUN cycles 20 and 40; oFirIn=111 then 001; oOutValid at cycles 22 and 42 with oOutData equal to iFirOut sampled then.
REQ-036 iEn=1, no data -> strobe at cycle 20 with oFirIn=000 and oUnderrun=1; iClrErr pulse -> oUnderrun=0 next cycle; iClrErr coincident with an underrun strobe -> oUnderrun stays 1.
REQ-037 Push 5 samples back-to-back with iEn=0 -> 4 accepted, oInReady=0 after 4th; one strobe later oInReady=1.
REQ-038 iEn dropped 1 cycle after a strobe -> FLUSH, oOutValid still issued at strobe+2, then IDLE; no further strobes; remaining FIFO data used after re-enable.
REQ-039 iRst asserted 1 cycle after a strobe -> no oOutValid for that strobe; all outputs at reset values; FIFO empty.
REQ-040 DIV=4, OUT_LAT=3 -> strobes every 4 cycles, each capture one cycle before next strobe.
